// File: rtl/memory_bus_pkg.sv
// Shared micro86 memory definitions: bus widths, RAM size, controller state
// encoding and the CPU request payload used by memory_bus and the RAM.
package memory_bus_pkg;

   localparam int unsigned CPU_ADDR_WIDTH         = 16;
   localparam int unsigned CPU_DATA_WIDTH         = 16;
   localparam int unsigned RAM_DATA_WIDTH         = 8;
   localparam int unsigned RAM_ADDR_WIDTH_DEFAULT = 12;
   localparam int unsigned RAM_SIZE_BYTES         = 1 << RAM_ADDR_WIDTH_DEFAULT;

   // Controller states
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_LO   = 3'd1,
      RD_HI   = 3'd2,
      RD_WAIT = 3'd3,
      WR_LO   = 3'd4,
      WR_HI   = 3'd5,
      DONE    = 3'd6,
      ERR     = 3'd7
   } bus_state_e;

   // CPU-side request as seen on the strobe cycle
   typedef struct packed {
      logic [CPU_ADDR_WIDTH-1:0] address;
      logic [CPU_DATA_WIDTH-1:0] wdata;
      logic                      width;
      logic                      read;
      logic                      write;
   } cpu_req_t;

   // Busy is asserted in every state that owns the RAM, plus ERR
   function automatic logic state_busy(input bus_state_e s);
      return (s != IDLE) && (s != DONE);
   endfunction

endpackage

// File: rtl/memory_bus_ram.sv
// Byte-wide synchronous RAM; read data is registered one clock after the
// address is presented. Sits beside memory_bus at the system top level.
//   clk            : clock
//   address_i      : byte address
//   data_in_i      : write byte
//   write_enable_i : write strobe
//   data_out_o     : registered read byte
module memory_bus_ram
   import memory_bus_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = RAM_ADDR_WIDTH_DEFAULT
) (
   input  logic                      clk,
   input  logic [ADDR_WIDTH-1:0]     address_i,
   input  logic [RAM_DATA_WIDTH-1:0] data_in_i,
   input  logic                      write_enable_i,
   output logic [RAM_DATA_WIDTH-1:0] data_out_o
);

   localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

   logic [RAM_DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [RAM_DATA_WIDTH-1:0] rdata_q;

   // Read-before-write array with registered output
   always_ff @(posedge clk) begin
      if (write_enable_i) begin
         mem_q[address_i] <= data_in_i;
      end
      rdata_q <= mem_q[address_i];
   end

   assign data_out_o = rdata_q;

endmodule

// File: rtl/memory_bus.sv
// CPU-to-RAM bridge: turns 16-bit byte/word CPU accesses into one or two
// byte accesses on an 8-bit registered-read RAM, little-endian.
//   clk, reset_n     : clock, async active-low reset
//   cpu_address      : byte address of the access
//   cpu_data_in      : write data (low byte at A)
//   cpu_width        : 0 byte, 1 word
//   cpu_read/_write  : request strobes, sampled only in IDLE
//   cpu_data_out     : last read result
//   cpu_busy         : access in progress
//   cpu_done         : one-cycle completion pulse
//   bus_error        : one-cycle failure pulse, coincident with cpu_done
//   ram_address      : RAM byte address
//   ram_data_in      : RAM write byte
//   ram_data_out     : RAM read byte (valid one clock after address)
//   ram_write_enable : RAM write strobe
module memory_bus
   import memory_bus_pkg::*;
#(
   parameter int unsigned RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEFAULT
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [CPU_ADDR_WIDTH-1:0] cpu_address,
   input  logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
   input  logic                      cpu_width,
   input  logic                      cpu_read,
   input  logic                      cpu_write,
   output logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
   output logic                      cpu_busy,
   output logic                      cpu_done,
   output logic                      bus_error,
   output logic [RAM_ADDR_WIDTH-1:0] ram_address,
   output logic [RAM_DATA_WIDTH-1:0] ram_data_in,
   input  logic [RAM_DATA_WIDTH-1:0] ram_data_out,
   output logic                      ram_write_enable
);

   bus_state_e                state_q, state_d;
   logic [RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [RAM_DATA_WIDTH-1:0] wr_hi_q, wr_hi_d;
   logic                      width_q, width_d;
   logic [RAM_DATA_WIDTH-1:0] lo_byte_q, lo_byte_d;
   logic [CPU_DATA_WIDTH-1:0] dout_q, dout_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;
   logic [RAM_ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
   logic [RAM_DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
   logic                      ram_we_q, ram_we_d;

   cpu_req_t                  req_c;
   logic                      req_valid_c;
   logic                      req_bad_c;
   logic [RAM_ADDR_WIDTH-1:0] req_addr_c;
   logic [RAM_ADDR_WIDTH-1:0] addr_inc_c;

   assign req_c = '{address: cpu_address,
                    wdata:   cpu_data_in,
                    width:   cpu_width,
                    read:    cpu_read,
                    write:   cpu_write};

   assign req_valid_c = req_c.read || req_c.write;
   // Out-of-range address or conflicting strobes go straight to ERR
   assign req_bad_c   = ((req_c.address >> RAM_ADDR_WIDTH) != '0) ||
                        (req_c.read && req_c.write);
   assign req_addr_c  = req_c.address[RAM_ADDR_WIDTH-1:0];
   // High byte address wraps within the RAM, never an error
   assign addr_inc_c  = RAM_ADDR_WIDTH'(addr_q + 1'b1);

   // Next-state and next-output decode
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wr_hi_d     = wr_hi_q;
      width_d     = width_q;
      lo_byte_d   = lo_byte_q;
      dout_d      = dout_q;
      ram_addr_d  = ram_addr_q;
      ram_wdata_d = ram_wdata_q;
      ram_we_d    = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (req_valid_c) begin
               addr_d  = req_addr_c;
               wr_hi_d = req_c.wdata[15:8];
               width_d = req_c.width;
               if (req_bad_c) begin
                  state_d = ERR;
                  done_d  = 1'b1;
                  err_d   = 1'b1;
                  if (req_c.read) begin
                     dout_d = '0;
                  end
               end else if (req_c.read) begin
                  state_d    = RD_LO;
                  ram_addr_d = req_addr_c;
               end else begin
                  state_d     = WR_LO;
                  ram_addr_d  = req_addr_c;
                  ram_wdata_d = req_c.wdata[7:0];
                  ram_we_d    = 1'b1;
               end
            end
         end
         RD_LO: begin
            if (width_q) begin
               state_d    = RD_HI;
               ram_addr_d = addr_inc_c;
            end else begin
               state_d = RD_WAIT;
            end
         end
         RD_HI: begin
            // Low byte arrives while the high address is presented
            lo_byte_d = ram_data_out;
            state_d   = RD_WAIT;
         end
         RD_WAIT: begin
            state_d = DONE;
            done_d  = 1'b1;
            dout_d  = width_q ? {ram_data_out, lo_byte_q}
                              : {8'h00, ram_data_out};
         end
         WR_LO: begin
            if (width_q) begin
               state_d     = WR_HI;
               ram_addr_d  = addr_inc_c;
               ram_wdata_d = wr_hi_q;
               ram_we_d    = 1'b1;
            end else begin
               state_d = DONE;
               done_d  = 1'b1;
            end
         end
         WR_HI: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE:    state_d = IDLE;
         ERR:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = state_busy(state_d);
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wr_hi_q     <= '0;
         width_q     <= 1'b0;
         lo_byte_q   <= '0;
         dout_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
         ram_we_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wr_hi_q     <= wr_hi_d;
         width_q     <= width_d;
         lo_byte_q   <= lo_byte_d;
         dout_q      <= dout_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         ram_addr_q  <= ram_addr_d;
         ram_wdata_q <= ram_wdata_d;
         ram_we_q    <= ram_we_d;
      end
   end

   assign cpu_data_out     = dout_q;
   assign cpu_busy         = busy_q;
   assign cpu_done         = done_q;
   assign bus_error        = err_q;
   assign ram_address      = ram_addr_q;
   assign ram_data_in      = ram_wdata_q;
   assign ram_write_enable = ram_we_q;

endmodule

// File: doc/memory_bus.md
MEMORY_BUS -- requirements
Module: memory_bus

Interface
REQ-001 SHALL have parameter RAM_ADDR_WIDTH, default 12, giving the RAM byte-address width (4096 bytes).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge.
REQ-003 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port cpu_address, input, 16 bits: byte address of the access.
REQ-005 SHALL have port cpu_data_in, input, 16 bits: write data, little-endian (low byte at address A).
REQ-006 SHALL have port cpu_width, input, 1 bit: 0 is a byte access, 1 is a word access.
REQ-007 SHALL have port cpu_read, input, 1 bit: read request strobe.
REQ-008 SHALL have port cpu_write, input, 1 bit: write request strobe.
REQ-009 SHALL have port cpu_data_out, output, 16 bits: read result.
REQ-010 SHALL have port cpu_busy, output, 1 bit: high while an access is in progress.
REQ-011 SHALL have port cpu_done, output, 1 bit: one-cycle completion pulse.
REQ-012 SHALL have port bus_error, output, 1 bit: one-cycle pulse, coincident with cpu_done, marking a failed access.
REQ-013 SHALL have port ram_address, output, RAM_ADDR_WIDTH bits: byte address to the RAM.
REQ-014 SHALL have port ram_data_in, output, 8 bits: write byte to the RAM.
REQ-015 SHALL have port ram_data_out, input, 8 bits: read byte from the RAM, registered by the RAM one clock after its address is presented.
REQ-016 SHALL have port ram_write_enable, output, 1 bit: RAM write strobe.

Function
REQ-017 SHALL use FSM states IDLE, RD_LO, RD_HI, RD_WAIT, WR_LO, WR_HI, DONE and ERR.
REQ-018 SHALL accept a request only in IDLE, when cpu_read or cpu_write is sampled high at posedge (edge 1), latching address, data, width and operation; strobes in any other state SHALL be ignored.
REQ-019 SHALL go from IDLE to ERR, not RD_LO or WR_LO, when cpu_address[15:RAM_ADDR_WIDTH] is nonzero or cpu_read and cpu_write are both high.
REQ-020 ERR SHALL last one cycle with cpu_done=1 and bus_error=1, perform no RAM write, load cpu_data_out=0 on a read, then return to IDLE.
REQ-021 A byte read SHALL follow RD_LO (ram_address=A), RD_WAIT, DONE; ram_data_out SHALL be captured at the end of RD_WAIT and zero-extended; cpu_done SHALL be high in the cycle after edge 3.
REQ-022 A word read SHALL follow RD_LO (A), RD_HI (A+1, low byte captured at end), RD_WAIT (high byte captured at end), DONE; cpu_done SHALL be high in the cycle after edge 4.
REQ-023 A byte write SHALL follow WR_LO (address A, data cpu_data_in[7:0], ram_write_enable=1), DONE; cpu_done SHALL be high in the cycle after edge 2.
REQ-024 A word write SHALL follow WR_LO, WR_HI (address A+1, data [15:8], ram_write_enable=1), DONE; cpu_done SHALL be high in the cycle after edge 3.
REQ-025 A+1 SHALL wrap modulo 2^RAM_ADDR_WIDTH, so a word at 0x0FFF uses bytes 0x0FFF and 0x0000, and this SHALL NOT raise an error.
REQ-026 ram_write_enable SHALL be high only in WR_LO and WR_HI, and ram_address and ram_data_in SHALL be driven from registered state, glitch-free.
REQ-027 cpu_busy SHALL be high in RD_*, WR_* and ERR, and low in IDLE and DONE.
REQ-028 DONE SHALL last exactly one cycle and then go to IDLE, so back-to-back requests are possible with one idle cycle between them.
REQ-029 cpu_data_out SHALL hold the last read result until the next read completes; writes and errors on write SHALL NOT change it.

Reset
REQ-030 While reset_n=0, SHALL set state=IDLE and force cpu_data_out, cpu_busy, cpu_done, bus_error, ram_address, ram_data_in and ram_write_enable to 0 immediately.
REQ-031 Reset mid-operation SHALL abort the access with no done pulse; the low byte of an interrupted word write may already be in RAM.

Structure
REQ-032 State encodings and the RAM size localparam SHALL live in a shared micro86 memory header included by memory_bus and the top level.
REQ-033 memory_bus SHALL instantiate no sub-module; the top level SHALL instantiate it beside ram, with ram_* wired point-to-point.

Verification
REQ-034 Byte write 0x5A to 0x0123, then byte read 0x0123 -> cpu_data_out=0x005A, done after edges 2 and 3 respectively, bus_error=0.
REQ-035 Word write 0xBEEF to 0x0FFF, then byte reads -> RAM[0x0FFF]=0xEF, RAM[0x0000]=0xBE; word read at 0x0FFF returns 0xBEEF.
REQ-036 Read of 0x1000 -> done and bus_error in the cycle after edge 1, cpu_data_out=0x0000, ram_write_enable never high.
REQ-037 cpu_read and cpu_write both high at 0x0010 -> bus_error pulse, RAM[0x0010] unchanged.
REQ-038 Strobe held high during busy -> exactly one access, and a second access starts only from IDLE after DONE.
REQ-039 reset_n low during WR_HI of word write 0x1234 to 0x0040 -> outputs 0 immediately, no cpu_done, RAM[0x0040]=0x34, RAM[0x0041] unchanged.
